// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative RV32M DIV/DIVU/REM/REMU unit for the Execute stage.
//                Restoring division, one quotient bit per cycle. Holds the
//                instruction in Execute through BusyE and honours FlushE.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [1:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            ValidE,
  output logic [XLEN-1:0] ResultE
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   c_cntInit = CW'(XLEN);
  localparam logic [CW-1:0]   c_cntLast = CW'(1);
  localparam logic [XLEN-1:0] c_minNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic [XLEN-1:0] r_quo;      // dividend shifts out MSB-first, quotient shifts in
  logic [XLEN-1:0] r_rem;      // partial remainder (always below the divisor)
  logic [XLEN-1:0] r_divisor;
  logic [CW-1:0]   r_cnt;
  logic            r_signA;
  logic            r_signB;
  logic [1:0]      r_funct;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signedOp;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_fast;
  logic [XLEN-1:0] w_fastRes;
  logic [XLEN-1:0] w_absA;
  logic [XLEN-1:0] w_absB;
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;
  logic [XLEN-1:0] w_quoNext;
  logic [XLEN-1:0] w_remNext;
  logic            w_negQ;
  logic            w_negR;
  logic [XLEN-1:0] w_final;

  // Start decode, special-case detection and operand magnitudes
  always_comb begin
    w_accept   = StartE & ~FlushE;
    w_signedOp = ~FunctE[0];
    w_divZero  = (SrcBE == '0);
    w_overflow = w_signedOp & (SrcAE == c_minNeg) & (SrcBE == '1);
    w_fast     = w_divZero | w_overflow;
    if (w_divZero) begin
      w_fastRes = FunctE[1] ? SrcAE : '1;
    end else begin
      w_fastRes = FunctE[1] ? '0 : SrcAE;
    end
    w_absA = (w_signedOp & SrcAE[XLEN-1]) ? (~SrcAE + 1'b1) : SrcAE;
    w_absB = (w_signedOp & SrcBE[XLEN-1]) ? (~SrcBE + 1'b1) : SrcBE;
  end

  // One restoring step plus sign fix-up of the final step's outcome
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    // Extra top bit: the shifted remainder can exceed 2^XLEN, so borrow needs XLEN+2 bits
    w_diff    = {1'b0, w_shift} - {2'b00, r_divisor};
    w_borrow  = w_diff[XLEN+1];
    w_remNext = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    w_quoNext = {r_quo[XLEN-2:0], ~w_borrow};
    w_negQ    = ~r_funct[0] & (r_signA ^ r_signB);
    w_negR    = ~r_funct[0] & r_signA;
    if (r_funct[1]) begin
      w_final = w_negR ? (~w_remNext + 1'b1) : w_remNext;
    end else begin
      w_final = w_negQ ? (~w_quoNext + 1'b1) : w_quoNext;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_stateNext = r_state;
    BusyE       = 1'b0;
    ValidE      = 1'b0;
    case (r_state)
      IDLE: begin
        BusyE = w_accept;
        if (w_accept) begin
          w_stateNext = w_fast ? DONE : RUN;
        end
      end
      RUN: begin
        BusyE = 1'b1;
        if (FlushE) begin
          w_stateNext = IDLE;
        end else if (r_cnt == c_cntLast) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        // StartE is ignored here: it is still the instruction just completed
        ValidE      = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_funct   <= 2'b00;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_quo     <= w_absA;
            r_rem     <= '0;
            r_divisor <= w_absB;
            r_cnt     <= c_cntInit;
            r_signA   <= SrcAE[XLEN-1];
            r_signB   <= SrcBE[XLEN-1];
            r_funct   <= FunctE;
            if (w_fast) begin
              r_result <= w_fastRes;
            end
          end
        end
        RUN: begin
          // A flushed divide leaves ResultE untouched
          if (!FlushE) begin
            r_quo <= w_quoNext;
            r_rem <= w_remNext;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == c_cntLast) begin
              r_result <= w_final;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ResultE = r_result;

endmodule
`default_nettype wire
